// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable digit-sequence detector.
package seq_det_pkg;

  localparam int DIGIT_W_DEF = 4;
  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  // Legacy fixed sequence, first digit at index 0.
  localparam int DEFAULT_LEN = 6;
  localparam int DEFAULT_PATTERN [DEFAULT_LEN] = '{1, 0, 2, 2, 1, 0};

  // Reset value of a pattern slot; slots beyond the legacy sequence are 0.
  function automatic int default_digit(input int idx);
    int r;
    r = 0;
    for (int j = 0; j < DEFAULT_LEN; j++) begin
      if (j == idx) r = DEFAULT_PATTERN[j];
    end
    return r;
  endfunction

  // Increment that holds at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_cfg.sv
// Pattern register file and pattern-length register for the sequence detector.
// Out-of-range slot indices and illegal lengths leave the stored state alone.
module seq_det_cfg
  import seq_det_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  localparam int IDX_W  = $clog2(MAX_LEN),
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             i_we,
  input  logic [IDX_W-1:0]                 i_idx,
  input  logic [DIGIT_W-1:0]               i_digit,
  input  logic [LEN_W-1:0]                 i_len,
  output logic [MAX_LEN-1:0][DIGIT_W-1:0]  o_pat,
  output logic [LEN_W-1:0]                 o_len
);

  // Legacy length clipped so a small MAX_LEN still resets to a legal value.
  localparam int RST_LEN = (DEFAULT_LEN <= MAX_LEN) ? DEFAULT_LEN : MAX_LEN;

  logic [MAX_LEN-1:0][DIGIT_W-1:0] r_pat;
  logic [LEN_W-1:0]                r_len;
  logic                            w_len_ok;

  assign w_len_ok = (i_len != '0) && (i_len <= LEN_W'(MAX_LEN));
  assign o_pat    = r_pat;
  assign o_len    = r_len;

  for (genvar s = 0; s < MAX_LEN; s++) begin : g_slot
    localparam logic [DIGIT_W-1:0] RST_DIGIT = DIGIT_W'(default_digit(s));

    // Each slot loads only when the write index names it exactly.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        r_pat[s] <= RST_DIGIT;
      end else if (i_we && (i_idx == IDX_W'(s))) begin
        r_pat[s] <= i_digit;
      end
    end
  end

  // Length register accepts only 1..MAX_LEN.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_len <= LEN_W'(RST_LEN);
    end else if (i_we && w_len_ok) begin
      r_len <= i_len;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable digit-sequence detector: history shift register, fill counter,
// suffix comparator, registered match pulse and saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int IDX_W  = $clog2(MAX_LEN),
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               I_VALID,
  input  logic [DIGIT_W-1:0] I,
  input  logic               CFG_WE,
  input  logic [IDX_W-1:0]   CFG_IDX,
  input  logic [DIGIT_W-1:0] CFG_DIGIT,
  input  logic [LEN_W-1:0]   CFG_LEN,
  input  logic               OVERLAP,
  input  logic               CNT_CLR,
  output logic               Y,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic [LEN_W-1:0]   FILL
);

  logic [MAX_LEN-1:0][DIGIT_W-1:0] w_pat;
  logic [LEN_W-1:0]                w_len;

  logic [MAX_LEN-1:0][DIGIT_W-1:0] r_hist;
  logic [LEN_W-1:0]                r_fill;
  logic                            r_y;
  logic [CNT_W-1:0]                r_cnt;

  logic                            w_accept;
  logic                            w_match;
  logic [IDX_W-1:0]                w_last_idx;
  logic [LEN_W:0]                  w_fill_next_ext;
  logic [LEN_W-1:0]                w_fill_inc;
  logic [CNT_W-1:0]                w_cnt_inc;

  seq_det_cfg #(
    .DIGIT_W (DIGIT_W),
    .MAX_LEN (MAX_LEN)
  ) u_cfg (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_we    (CFG_WE),
    .i_idx   (CFG_IDX),
    .i_digit (CFG_DIGIT),
    .i_len   (CFG_LEN),
    .o_pat   (w_pat),
    .o_len   (w_len)
  );

  // A config write swallows any digit presented on the same cycle.
  assign w_accept        = I_VALID && !CFG_WE;
  assign w_fill_next_ext = {1'b0, r_fill} + (LEN_W + 1)'(1);
  assign w_fill_inc      = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_cnt_inc       = CNT_W'(sat_inc(32'(r_cnt), 32'({CNT_W{1'b1}})));

  // Compare the incoming digit plus the newest LEN-1 history entries against the pattern.
  always_comb begin
    w_last_idx = IDX_W'(w_len - LEN_W'(1));
    w_match    = w_accept
              && (w_fill_next_ext >= {1'b0, w_len})
              && (I == w_pat[w_last_idx]);
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((LEN_W'(k) < w_len) && (r_hist[k-1] != w_pat[w_last_idx - IDX_W'(k)])) begin
        w_match = 1'b0;
      end
    end
  end

  // History and fill: cleared by config writes and by non-overlapping matches.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (CFG_WE || (w_match && !OVERLAP)) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      r_hist <= {r_hist[MAX_LEN-2:0], I};
      r_fill <= w_fill_inc;
    end
  end

  // One-cycle match pulse, registered.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_match;
    end
  end

  // Match counter; a clear wins over a match on the same edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (CNT_CLR) begin
      r_cnt <= '0;
    end else if (w_match) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign Y         = r_y;
  assign MATCH_CNT = r_cnt;
  assign FILL      = r_fill;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed, table-driven bench for seq_detector_prog (CNT_W=2 so saturation is reachable).
module tb_seq_detector_prog;

  localparam int DW = 4;
  localparam int ML = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] din;
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic [DW-1:0] cfg_digit;
  logic [3:0]    cfg_len;
  logic          overlap;
  logic          cnt_clr;
  logic          y;
  logic [CW-1:0] match_cnt;
  logic [3:0]    fill;

  seq_detector_prog #(.DIGIT_W(DW), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .I_VALID   (i_valid),
    .I         (din),
    .CFG_WE    (cfg_we),
    .CFG_IDX   (cfg_idx),
    .CFG_DIGIT (cfg_digit),
    .CFG_LEN   (cfg_len),
    .OVERLAP   (overlap),
    .CNT_CLR   (cnt_clr),
    .Y         (y),
    .MATCH_CNT (match_cnt),
    .FILL      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    valid;
    int    d;
    bit    ovl;
    bit    clr;
    bit    exp_y;
    int    exp_cnt;
    int    exp_fill;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input string tag, input bit v, input int d, input bit ovl,
                              input bit clr, input bit ey, input int ecnt, input int efill);
    vec_t r;
    r.tag = tag; r.valid = v; r.d = d; r.ovl = ovl; r.clr = clr;
    r.exp_y = ey; r.exp_cnt = ecnt; r.exp_fill = efill;
    vecs.push_back(r);
  endfunction

  task automatic idle_inputs();
    i_valid = 1'b0; din = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_digit = '0; cfg_len = '0; cnt_clr = 1'b0;
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      i_valid = vecs[i].valid;
      din     = DW'(vecs[i].d);
      overlap = vecs[i].ovl;
      cnt_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].y", vecs[i].tag, i), 32'(y), 32'(vecs[i].exp_y));
      chk($sformatf("%s[%0d].cnt", vecs[i].tag, i), 32'(match_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("%s[%0d].fill", vecs[i].tag, i), 32'(fill), 32'(vecs[i].exp_fill));
    end
    idle_inputs();
    vecs.delete();
  endtask

  task automatic do_reset(input string nm);
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk({nm, ".y"}, 32'(y), 32'd0);
    chk({nm, ".cnt"}, 32'(match_cnt), 32'd0);
    chk({nm, ".fill"}, 32'(fill), 32'd0);
  endtask

  task automatic cfg_write(input string nm, input int idx, input int dig, input int len,
                           input bit v, input int d);
    cfg_we    = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_digit = DW'(dig);
    cfg_len   = 4'(len);
    i_valid   = v;
    din       = DW'(d);
    @(posedge clk);
    #1;
    chk({nm, ".y"}, 32'(y), 32'd0);
    chk({nm, ".fill"}, 32'(fill), 32'd0);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    overlap = 1'b1;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.y", 32'(y), 32'd0);
    chk("reset.cnt", 32'(match_cnt), 32'd0);
    chk("reset.fill", 32'(fill), 32'd0);
    rst_n = 1'b1;

    // Test 1: default legacy pattern, back-to-back digits.
    add("t1", 1, 1, 1, 0, 0, 0, 1);
    add("t1", 1, 0, 1, 0, 0, 0, 2);
    add("t1", 1, 2, 1, 0, 0, 0, 3);
    add("t1", 1, 2, 1, 0, 0, 0, 4);
    add("t1", 1, 1, 1, 0, 0, 0, 5);
    add("t1", 1, 0, 1, 0, 1, 1, 6);
    add("t1", 1, 2, 1, 0, 0, 1, 7);
    add("t1", 1, 2, 1, 0, 0, 1, 8);
    add("t1", 1, 1, 1, 0, 0, 1, 8);
    add("t1", 1, 0, 1, 0, 1, 2, 8);
    run_vecs();

    // Test 2: same pattern with idle gaps; Y must last exactly one cycle.
    do_reset("t2rst");
    add("t2", 1, 1, 1, 0, 0, 0, 1); add("t2", 0, 9, 1, 0, 0, 0, 1);
    add("t2", 1, 0, 1, 0, 0, 0, 2); add("t2", 0, 9, 1, 0, 0, 0, 2);
    add("t2", 1, 2, 1, 0, 0, 0, 3); add("t2", 0, 9, 1, 0, 0, 0, 3);
    add("t2", 1, 2, 1, 0, 0, 0, 4); add("t2", 0, 9, 1, 0, 0, 0, 4);
    add("t2", 1, 1, 1, 0, 0, 0, 5); add("t2", 0, 0, 1, 0, 0, 0, 5);
    add("t2", 1, 0, 1, 0, 1, 1, 6); add("t2", 0, 0, 1, 0, 0, 1, 6);
    add("t2", 0, 0, 1, 0, 0, 1, 6);
    run_vecs();

    // Test 3: pattern 1,2,1 overlapping then non-overlapping.
    cfg_write("t3w0", 0, 1, 3, 0, 0);
    cfg_write("t3w1", 1, 2, 3, 0, 0);
    cfg_write("t3w2", 2, 1, 3, 0, 0);
    add("t3a", 0, 0, 1, 1, 0, 0, 0);
    add("t3a", 1, 1, 1, 0, 0, 0, 1);
    add("t3a", 1, 2, 1, 0, 0, 0, 2);
    add("t3a", 1, 1, 1, 0, 1, 1, 3);
    add("t3a", 1, 2, 1, 0, 0, 1, 4);
    add("t3a", 1, 1, 1, 0, 1, 2, 5);
    run_vecs();
    cfg_write("t3w3", 0, 1, 3, 0, 0);
    add("t3b", 0, 0, 0, 1, 0, 0, 0);
    add("t3b", 1, 1, 0, 0, 0, 0, 1);
    add("t3b", 1, 2, 0, 0, 0, 0, 2);
    add("t3b", 1, 1, 0, 0, 1, 1, 0);
    add("t3b", 1, 2, 0, 0, 0, 1, 1);
    add("t3b", 1, 1, 0, 0, 0, 1, 2);
    run_vecs();

    // Test 4: self-overlapping pattern 1,1,0, then illegal lengths are ignored.
    cfg_write("t4w0", 0, 1, 3, 0, 0);
    cfg_write("t4w1", 1, 1, 3, 0, 0);
    cfg_write("t4w2", 2, 0, 3, 0, 0);
    add("t4a", 0, 0, 1, 1, 0, 0, 0);
    add("t4a", 1, 1, 1, 0, 0, 0, 1);
    add("t4a", 1, 1, 1, 0, 0, 0, 2);
    add("t4a", 1, 1, 1, 0, 0, 0, 3);
    add("t4a", 1, 0, 1, 0, 1, 1, 4);
    run_vecs();
    cfg_write("t4len0", 7, 9, 0, 0, 0);
    cfg_write("t4len9", 7, 9, 9, 0, 0);
    add("t4b", 1, 1, 1, 0, 0, 1, 1);
    add("t4b", 1, 1, 1, 0, 0, 1, 2);
    add("t4b", 1, 0, 1, 0, 1, 2, 3);
    run_vecs();

    // Test 5: LEN=1 pattern 7, saturation, clear-vs-match priority, same-edge OVERLAP.
    cfg_write("t5w0", 0, 7, 1, 0, 0);
    add("t5", 0, 0, 1, 1, 0, 0, 0);
    add("t5", 1, 7, 1, 0, 1, 1, 1);
    add("t5", 1, 7, 1, 0, 1, 2, 2);
    add("t5", 1, 7, 1, 0, 1, 3, 3);
    add("t5", 1, 7, 1, 0, 1, 3, 4);
    add("t5", 1, 7, 1, 0, 1, 3, 5);
    add("t5", 1, 7, 1, 1, 1, 0, 6);
    add("t5", 1, 7, 0, 0, 1, 1, 0);
    add("t5", 0, 7, 1, 0, 0, 1, 0);
    add("t5", 1, 3, 1, 0, 0, 1, 1);
    run_vecs();

    // Test 6: reset mid-sequence restores the legacy pattern; config beats a valid digit.
    add("t6a", 1, 1, 1, 0, 0, 1, 2);
    add("t6a", 1, 0, 1, 0, 0, 1, 3);
    add("t6a", 1, 2, 1, 0, 0, 1, 4);
    add("t6a", 1, 2, 1, 0, 0, 1, 5);
    add("t6a", 1, 1, 1, 0, 0, 1, 6);
    run_vecs();
    do_reset("t6rst");
    add("t6b", 1, 0, 1, 0, 0, 0, 1);
    add("t6b", 1, 1, 1, 0, 0, 0, 2);
    add("t6b", 1, 0, 1, 0, 0, 0, 3);
    add("t6b", 1, 2, 1, 0, 0, 0, 4);
    add("t6b", 1, 2, 1, 0, 0, 0, 5);
    add("t6b", 1, 1, 1, 0, 0, 0, 6);
    add("t6b", 1, 0, 1, 0, 1, 1, 7);
    add("t6b", 1, 2, 1, 0, 0, 1, 8);
    add("t6b", 1, 2, 1, 0, 0, 1, 8);
    add("t6b", 1, 1, 1, 0, 0, 1, 8);
    run_vecs();
    cfg_write("t6cfgvalid", 7, 0, 0, 1, 0);
    chk("t6cfgvalid.cnt", 32'(match_cnt), 32'd1);
    add("t6c", 1, 0, 1, 0, 0, 1, 1);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
